// File: rtl/alu_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : alu_restoring_divider
//  Purpose  : Sequential restoring divider for the integer ALU. It handles one
//             quotient bit per cycle and uses a start/busy/done handshake.
//  Option   : ALU_DIV_SIGNED_EN - treat operands as two's-complement
//             (quotient truncates toward zero)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;      // partial remainder; always < divisor, so the top bit of the WIDTH+1 value is implicit zero
  logic [WIDTH-1:0] r_q;        // dividend bits shift out and quotient bits shift in
  logic [WIDTH-1:0] r_div;      // captured divisor (magnitude in signed builds)
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dbz;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_rshift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rnext;
  logic [WIDTH-1:0] w_qnext;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  // One restoring step: shift in the next dividend bit, then do a trial subtraction.
  assign w_rshift = {r_rem, r_q[WIDTH-1]};
  assign w_diff   = w_rshift - {1'b0, r_div};
  assign w_borrow = w_diff[WIDTH];
  assign w_rnext  = w_borrow ? w_rshift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_qnext  = {r_q[WIDTH-2:0], ~w_borrow};

`ifdef ALU_DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_dvd_neg;
  logic w_dvs_neg;

  // Run the core on magnitudes, then fix the signs at the end.
  // For most-negative / -1, the quotient magnitude wraps to the most-negative value.
  assign w_dvd_neg = dividend[WIDTH-1];
  assign w_dvs_neg = divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign w_dvs_mag = w_dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
  assign w_q_final = r_neg_q ? (~w_qnext + WIDTH'(1)) : w_qnext;
  assign w_r_final = r_neg_r ? (~w_rnext + WIDTH'(1)) : w_rnext;

  // The sign flags are captured together with the operands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == S_IDLE && start && divisor != '0) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end
`else
  assign w_dvd_mag = dividend;
  assign w_dvs_mag = divisor;
  assign w_q_final = w_qnext;
  assign w_r_final = w_rnext;
`endif

  // Control FSM and datapath. Results load on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_remo  <= dividend;
              r_dbz   <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_rem   <= '0;
              r_q     <= w_dvd_mag;
              r_div   <= w_dvs_mag;
              r_cnt   <= CW'(WIDTH);
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rnext;
          r_q   <= w_qnext;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_quot  <= w_q_final;
            r_remo  <= w_r_final;
            r_dbz   <= 1'b0;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_restoring_divider
//  Purpose  : Self-checking bench for alu_restoring_divider. It uses directed
//             cases with literal results and randomized traffic, and checks
//             every cycle against a behavioural reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_restoring_divider;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         dz;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  alu_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for one divide
  function automatic res_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
`ifdef ALU_DIV_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == '0) begin
      r.q   = '1;
      r.rem = a;
      r.dz  = 1'b1;
      return r;
    end
    r.dz = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sa == -(1 << (W - 1)) && sb == -1) begin
      r.q   = W'(sa);
      r.rem = '0;
    end else begin
      r.q   = W'(sa / sb);
      r.rem = W'(sa % sb);
    end
`else
    r.q   = a / b;
    r.rem = a % b;
`endif
    return r;
  endfunction

  // Timing model: it counts the busy cycles left and presents the result on the done cycle
  int   m_cnt = 0;
  logic m_done = 1'b0;
  res_t m_res = '0;
  res_t p_res = '0;
  logic m_busy;
  assign m_busy = (m_cnt > 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_res  <= p_res;
        end
      end else if (!m_done && start) begin
        if (divisor == '0) begin
          m_done <= 1'b1;
          m_res  <= ref_div(dividend, divisor);
        end else begin
          m_cnt <= W;
          p_res <= ref_div(dividend, divisor);
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({busy, done, quotient, remainder, div_by_zero} !== {m_busy, m_done, m_res}) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got busy=%b done=%b q=%h r=%h dbz=%b, want busy=%b done=%b q=%h r=%h dbz=%b",
                 $time, busy, done, quotient, remainder, div_by_zero,
                 m_busy, m_done, m_res.q, m_res.rem, m_res.dz);
      end
    end
  end

  // Directed divide with literal expectations and a latency check. poke re-pulses start mid-run.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                         input int elat, input string name, input bit poke);
    int lat;
    bit seen;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    seen  = 1'b0;
    while (!seen && lat <= 20) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (poke && lat == 2) begin
          start    = 1'b1;
          dividend = 4'd15;
          divisor  = 4'd5;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    n_vec++;
    if (!seen || lat != elat || quotient !== eq || remainder !== er || div_by_zero !== ez) begin
      n_fail++;
      $display("FAIL %s: got seen=%0d lat=%0d q=%h r=%h dbz=%b, want lat=%0d q=%h r=%h dbz=%b",
               name, seen, lat, quotient, remainder, div_by_zero, elat, eq, er, ez);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || quotient !== eq || remainder !== er) begin
      n_fail++;
      $display("FAIL %s_hold: got done=%b q=%h r=%h, want done=0 q=%h r=%h",
               name, done, quotient, remainder, eq, er);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
        n_fail++;
        $display("FAIL reset_idle: got busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
                 busy, done, quotient, remainder, div_by_zero);
      end
    end

`ifdef ALU_DIV_SIGNED_EN
    run_div(4'd7,    4'd0,    4'hF,    4'd7,    1'b1, 1,     "s_dbz",     1'b0);
    run_div(4'd6,    4'd3,    4'd2,    4'd0,    1'b0, W + 1, "s_6_3",     1'b0);
    run_div(4'b1001, 4'd2,    4'b1101, 4'b1111, 1'b0, W + 1, "s_m7_2",    1'b0);
    run_div(4'd7,    4'b1110, 4'b1101, 4'd1,    1'b0, W + 1, "s_7_m2",    1'b0);
    run_div(4'b1000, 4'b1111, 4'b1000, 4'd0,    1'b0, W + 1, "s_m8_m1",   1'b0);
    run_div(4'd5,    4'd2,    4'd2,    4'd1,    1'b0, W + 1, "s_poke",    1'b1);
`else
    run_div(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, W + 1, "u_13_3", 1'b0);
    run_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, W + 1, "u_15_1", 1'b0);
    run_div(4'd2,  4'd7, 4'd0,  4'd2, 1'b0, W + 1, "u_2_7",  1'b0);
    run_div(4'd7,  4'd0, 4'hF,  4'd7, 1'b1, 1,     "u_dbz",  1'b0);
    run_div(4'd9,  4'd4, 4'd2,  4'd1, 1'b0, W + 1, "u_9_4",  1'b0);
    run_div(4'd13, 4'd3, 4'd4,  4'd1, 1'b0, W + 1, "u_poke", 1'b1);
`endif
    run_div(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, W + 1, "zero_dvd", 1'b0);

    // Reset asserted during the second RUN cycle
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b done=%b q=%h r=%h dbz=%b, want all zero",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (6) @(negedge clk);
    run_div(4'd6, 4'd2, 4'd3, 4'd0, 1'b0, W + 1, "after_reset", 1'b0);

    // Randomized traffic: starts, zero divisors and occasional resets
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) == 0);
      dividend = W'($urandom);
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rst_n    = ($urandom_range(0, 149) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
